// File: rtl/usb_rx_pkg.sv
// rtl/usb_rx_pkg.sv - shared types and constants for the USB full-speed receive line decoder
package usb_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        EOP_WAIT
    } rx_state_t;

    typedef enum logic [1:0] {
        LINE_J,
        LINE_K,
        LINE_SE0
    } line_state_t;

    localparam logic [2:0] STUFF_LIMIT = 3'd6;

    // SE1 is not a legal bus state, so it is folded into J.
    function automatic line_state_t decode_line(input logic d_plus, input logic d_minus);
        line_state_t result;
        if (!d_plus && !d_minus) begin
            result = LINE_SE0;
        end else if (!d_plus) begin
            result = LINE_K;
        end else begin
            result = LINE_J;
        end
        return result;
    endfunction

endpackage

// File: rtl/usb_rx_bit_timer.sv
// rtl/usb_rx_bit_timer.sv - bit-period counter with edge resync and sample point strobe
module usb_rx_bit_timer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_PHASE = 3
) (
    input  logic clk,
    input  logic n_rst,
    input  logic enable,
    input  logic line_edge,
    output logic sample_now
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] count;
    logic [CW-1:0] base;

    // The edge cycle itself counts as phase 0 of the new bit window.
    assign base = line_edge ? '0 : count;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count <= '0;
        end else if (!enable) begin
            count <= '0;
        end else if (base == CW'(CLKS_PER_BIT - 1)) begin
            count <= '0;
        end else begin
            count <= base + CW'(1);
        end
    end

    assign sample_now = (count == CW'(SAMPLE_PHASE)) && !line_edge;

endmodule

// File: rtl/usb_rx_line_decoder.sv
// rtl/usb_rx_line_decoder.sv - USB full-speed receive line decoder: sync, NRZI, unstuff, EOP detect
module usb_rx_line_decoder
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_PHASE = 3
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d_plus_in,
    input  logic d_minus_in,
    input  logic rx_enable,
    output logic rx_bit,
    output logic bit_strobe,
    output logic eop,
    output logic stuff_err,
    output logic line_idle
);

    logic        dp_meta;
    logic        dp_sync;
    logic        dm_meta;
    logic        dm_sync;
    logic        d_plus_prev;
    logic        line_edge;
    logic        sample_now;
    logic        timer_en;
    logic        nrzi_bit;
    logic        prev_sample;
    logic [2:0]  ones_cnt;
    line_state_t line;
    rx_state_t   state;

    // Synchronizers preload to J so a reset never looks like a K edge.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            dp_meta     <= 1'b1;
            dp_sync     <= 1'b1;
            dm_meta     <= 1'b0;
            dm_sync     <= 1'b0;
            d_plus_prev <= 1'b1;
        end else begin
            dp_meta     <= d_plus_in;
            dp_sync     <= dp_meta;
            dm_meta     <= d_minus_in;
            dm_sync     <= dm_meta;
            d_plus_prev <= dp_sync;
        end
    end

    assign line      = decode_line(dp_sync, dm_sync);
    assign line_edge = (dp_sync != d_plus_prev);
    assign nrzi_bit  = (dp_sync == prev_sample);
    assign timer_en  = rx_enable && ((state != IDLE) || (line_edge && (line == LINE_K)));

    usb_rx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SAMPLE_PHASE (SAMPLE_PHASE)
    ) u_bit_timer (
        .clk        (clk),
        .n_rst      (n_rst),
        .enable     (timer_en),
        .line_edge  (line_edge),
        .sample_now (sample_now)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state       <= IDLE;
            prev_sample <= 1'b1;
            ones_cnt    <= 3'd0;
            rx_bit      <= 1'b0;
            bit_strobe  <= 1'b0;
            eop         <= 1'b0;
            stuff_err   <= 1'b0;
            line_idle   <= 1'b1;
        end else begin
            bit_strobe <= 1'b0;
            eop        <= 1'b0;
            stuff_err  <= 1'b0;
            if (!rx_enable) begin
                state       <= IDLE;
                prev_sample <= 1'b1;
                ones_cnt    <= 3'd0;
                line_idle   <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        prev_sample <= 1'b1;
                        ones_cnt    <= 3'd0;
                        if (line_edge && (line == LINE_K)) begin
                            state     <= RECV;
                            line_idle <= 1'b0;
                        end
                    end
                    RECV: begin
                        if (sample_now) begin
                            // SE0 outranks the stuffing check, so a pending stuff bit is dropped.
                            if (line == LINE_SE0) begin
                                eop   <= 1'b1;
                                state <= EOP_WAIT;
                            end else begin
                                prev_sample <= dp_sync;
                                if (ones_cnt == STUFF_LIMIT) begin
                                    ones_cnt  <= 3'd0;
                                    stuff_err <= nrzi_bit;
                                end else begin
                                    bit_strobe <= 1'b1;
                                    rx_bit     <= nrzi_bit;
                                    ones_cnt   <= nrzi_bit ? ones_cnt + 3'd1 : 3'd0;
                                end
                            end
                        end
                    end
                    EOP_WAIT: begin
                        if (sample_now && (line == LINE_J)) begin
                            state       <= IDLE;
                            prev_sample <= 1'b1;
                            ones_cnt    <= 3'd0;
                            line_idle   <= 1'b1;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        line_idle <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_rx_line_decoder.sv
// tb/tb_usb_rx_line_decoder.sv - self-checking bench for usb_rx_line_decoder
module tb_usb_rx_line_decoder;

    localparam int CPB = 8;
    localparam int SP  = 3;

    logic clk        = 1'b0;
    logic n_rst      = 1'b0;
    logic d_plus_in  = 1'b1;
    logic d_minus_in = 1'b0;
    logic rx_enable  = 1'b1;
    logic rx_bit;
    logic bit_strobe;
    logic eop;
    logic stuff_err;
    logic line_idle;

    usb_rx_line_decoder #(
        .CLKS_PER_BIT (CPB),
        .SAMPLE_PHASE (SP)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .d_plus_in  (d_plus_in),
        .d_minus_in (d_minus_in),
        .rx_enable  (rx_enable),
        .rx_bit     (rx_bit),
        .bit_strobe (bit_strobe),
        .eop        (eop),
        .stuff_err  (stuff_err),
        .line_idle  (line_idle)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic dp; logic dm; logic en; logic rst; } stim_t;
    typedef struct packed { logic strobe; logic bv; logic eop; logic serr; logic idle; } obs_t;

    localparam obs_t RESET_OBS = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    stim_t stim[$];
    obs_t  obs[$];
    obs_t  expv[$];
    logic  sent[$];
    logic  got[$];
    int    total = 0;
    int    bad   = 0;
    logic  lvl;
    logic  cur_en;
    logic  alt;
    int    ones_tx;
    int    jit_mode;
    int    drift;

    task automatic hold(input logic dp, input logic dm, input int n);
        stim_t s;
        s = '{dp, dm, cur_en, 1'b0};
        repeat (n) stim.push_back(s);
    endtask

    // Jitter modes: 0 nominal, 1 alternating 7/9, 2 random with cumulative drift kept within one clock.
    function automatic int bit_len();
        int d;
        if (jit_mode == 1) begin
            alt = ~alt;
            return alt ? CPB - 1 : CPB + 1;
        end else if (jit_mode == 2) begin
            d = int'($urandom_range(0, 2)) - 1;
            if (drift + d > 1 || drift + d < -1) d = 0;
            drift += d;
            return CPB + d;
        end
        return CPB;
    endfunction

    task automatic tx_raw(input logic b);
        if (!b) lvl = ~lvl;
        hold(lvl, ~lvl, bit_len());
    endtask

    task automatic tx_bit(input logic b);
        sent.push_back(b);
        tx_raw(b);
        if (b) begin
            ones_tx++;
            if (ones_tx == 6) begin
                tx_raw(1'b0);
                ones_tx = 0;
            end
        end else begin
            ones_tx = 0;
        end
    endtask

    task automatic tx_sync();
        ones_tx = 0;
        for (int i = 0; i < 8; i++) tx_bit(i == 7);
    endtask

    task automatic tx_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) tx_bit(v[i]);
    endtask

    task automatic tx_eop();
        hold(1'b0, 1'b0, 2 * CPB);
        lvl = 1'b1;
        hold(1'b1, 1'b0, 3 * CPB);
    endtask

    task automatic start_scenario(input int jm);
        stim_t r;
        stim.delete();
        sent.delete();
        cur_en   = 1'b1;
        jit_mode = jm;
        drift    = 0;
        alt      = 1'b0;
        lvl      = 1'b1;
        r = '{1'b1, 1'b0, 1'b1, 1'b1};
        repeat (3) stim.push_back(r);
        hold(1'b1, 1'b0, 6);
    endtask

    // Reference: sample instants are SP clocks past the most recent D+ change, then every CPB clocks.
    task automatic model();
        logic [1:0] sy[$];
        logic [1:0] cur;
        logic       pdp;
        logic       e;
        logic       b;
        logic       prev;
        int         mode;
        int         anchor;
        int         ones;
        obs_t       o;
        mode = 0; anchor = 0; ones = 0; prev = 1'b1;
        expv.delete();
        expv.push_back(RESET_OBS);
        for (int t = 0; t < stim.size(); t++) begin
            if (t < 2) cur = 2'b10;
            else if (stim[t-1].rst || stim[t-2].rst) cur = 2'b10;
            else cur = {stim[t-2].dp, stim[t-2].dm};
            sy.push_back(cur);
            if (t == 0) pdp = 1'b1;
            else if (stim[t-1].rst) pdp = 1'b1;
            else pdp = sy[t-1][1];
            e = (cur[1] != pdp);
            o = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            if (stim[t].rst) begin
                mode = 0; ones = 0; prev = 1'b1;
                expv.push_back(RESET_OBS);
                continue;
            end
            if (!stim[t].en) begin
                mode = 0; ones = 0; prev = 1'b1;
            end else if (mode == 0) begin
                if (e && cur == 2'b01) begin
                    mode = 1;
                    anchor = t;
                end
            end else if (e) begin
                anchor = t;
            end else if ((t - anchor) % CPB == SP) begin
                if (mode == 1) begin
                    if (cur == 2'b00) begin
                        o.eop = 1'b1;
                        mode = 2;
                    end else begin
                        b = (cur[1] == prev);
                        prev = cur[1];
                        if (ones == 6) begin
                            ones = 0;
                            o.serr = b;
                        end else begin
                            o.strobe = 1'b1;
                            o.bv = b;
                            ones = b ? ones + 1 : 0;
                        end
                    end
                end else if (cur[1]) begin
                    mode = 0; ones = 0; prev = 1'b1;
                end
            end
            o.idle = (mode == 0);
            expv.push_back(o);
        end
    endtask

    task automatic run_stim();
        obs.delete();
        foreach (stim[i]) begin
            @(negedge clk);
            obs.push_back('{bit_strobe, rx_bit, eop, stuff_err, line_idle});
            n_rst      = ~stim[i].rst;
            d_plus_in  = stim[i].dp;
            d_minus_in = stim[i].dm;
            rx_enable  = stim[i].en;
        end
        @(negedge clk);
        obs.push_back('{bit_strobe, rx_bit, eop, stuff_err, line_idle});
        model();
    endtask

    function automatic obs_t masked(input obs_t o);
        obs_t m;
        m = o;
        if (!o.strobe) m.bv = 1'b0;
        return m;
    endfunction

    task automatic collect(input int from);
        got.delete();
        for (int t = from; t < obs.size(); t++)
            if (obs[t].strobe) got.push_back(obs[t].bv);
    endtask

    task automatic count_pulses(input int lo, input int hi, output int ns, output int ne,
                                output int nx, output int nbusy);
        ns = 0; ne = 0; nx = 0; nbusy = 0;
        for (int t = lo; t <= hi && t < obs.size(); t++) begin
            ns += int'(obs[t].strobe);
            ne += int'(obs[t].eop);
            nx += int'(obs[t].serr);
            nbusy += int'(!obs[t].idle);
        end
    endtask

    task automatic test_reset();
        start_scenario(0);
        hold(1'b1, 1'b0, 4);
        run_stim();
        total++;
        if (obs[1] !== RESET_OBS) begin
            bad++; $display("FAIL reset_values: got %b required %b", obs[1], RESET_OBS);
        end
        for (int t = 1; t < obs.size(); t++) begin
            total++;
            if (masked(obs[t]) !== masked(expv[t])) begin
                bad++; $display("FAIL reset_model cycle %0d: got %b required %b", t, obs[t], expv[t]);
            end
        end
    endtask

    task automatic test_idle_line();
        int ns, ne, nx, nb;
        start_scenario(0);
        hold(1'b1, 1'b0, 100);
        run_stim();
        count_pulses(1, obs.size() - 1, ns, ne, nx, nb);
        total++;
        if (ns + ne + nx + nb != 0) begin
            bad++; $display("FAIL idle_quiet: got strobe=%0d eop=%0d serr=%0d busy=%0d required all 0", ns, ne, nx, nb);
        end
        for (int t = 1; t < obs.size(); t++) begin
            total++;
            if (masked(obs[t]) !== masked(expv[t])) begin
                bad++; $display("FAIL idle_model cycle %0d: got %b required %b", t, obs[t], expv[t]);
            end
        end
    endtask

    task automatic test_sync();
        int first;
        int first_k;
        logic [7:0] byte_v;
        start_scenario(0);
        first_k = stim.size();
        tx_sync();
        tx_eop();
        run_stim();
        first = -1;
        for (int t = 0; t < obs.size(); t++) if (obs[t].strobe && first < 0) first = t;
        total++;
        if (first != first_k + 2 + SP + 1) begin
            bad++; $display("FAIL sync_latency: got first strobe at %0d required %0d", first, first_k + 2 + SP + 1);
        end
        collect(0);
        byte_v = '0;
        for (int i = 0; i < 8 && i < got.size(); i++) byte_v[i] = got[i];
        total++;
        if (got.size() != 8 || byte_v !== 8'h80) begin
            bad++; $display("FAIL sync_byte: got %0d bits value %h required 8 bits value 80", got.size(), byte_v);
        end
        for (int t = 1; t < obs.size(); t++) begin
            total++;
            if (masked(obs[t]) !== masked(expv[t])) begin
                bad++; $display("FAIL sync_model cycle %0d: got %b required %b", t, obs[t], expv[t]);
            end
        end
    endtask

    task automatic test_stuffed_ones();
        int ns, ne, nx, nb;
        start_scenario(0);
        tx_sync();
        for (int i = 0; i < 7; i++) tx_bit(1'b1);
        tx_eop();
        run_stim();
        count_pulses(1, obs.size() - 1, ns, ne, nx, nb);
        total++;
        if (ns != 15 || nx != 0 || ne != 1) begin
            bad++; $display("FAIL stuffed_counts: got strobe=%0d serr=%0d eop=%0d required 15 0 1", ns, nx, ne);
        end
        collect(0);
        for (int i = 0; i < sent.size(); i++) begin
            total++;
            if (i >= got.size() || got[i] !== sent[i]) begin
                bad++; $display("FAIL stuffed_bit %0d: got %b required %b", i, (i < got.size()) ? got[i] : 1'bx, sent[i]);
            end
        end
        for (int t = 1; t < obs.size(); t++) begin
            total++;
            if (masked(obs[t]) !== masked(expv[t])) begin
                bad++; $display("FAIL stuffed_model cycle %0d: got %b required %b", t, obs[t], expv[t]);
            end
        end
    endtask

    task automatic test_stuff_error();
        int ns, ne, nx, nb;
        start_scenario(0);
        tx_sync();
        repeat (6) hold(lvl, ~lvl, CPB);
        tx_eop();
        run_stim();
        count_pulses(1, obs.size() - 1, ns, ne, nx, nb);
        total++;
        if (ns != 13 || nx != 1 || ne != 1) begin
            bad++; $display("FAIL stufferr_counts: got strobe=%0d serr=%0d eop=%0d required 13 1 1", ns, nx, ne);
        end
        for (int t = 1; t < obs.size(); t++) begin
            total++;
            if (masked(obs[t]) !== masked(expv[t])) begin
                bad++; $display("FAIL stufferr_model cycle %0d: got %b required %b", t, obs[t], expv[t]);
            end
        end
    endtask

    task automatic test_eop();
        int ns, ne, nx, nb;
        start_scenario(0);
        tx_sync();
        tx_byte(8'($urandom));
        tx_eop();
        run_stim();
        count_pulses(1, obs.size() - 1, ns, ne, nx, nb);
        total++;
        if (ne != 1 || obs[obs.size()-1].idle !== 1'b1) begin
            bad++; $display("FAIL eop_once: got eop=%0d final idle=%b required 1 1", ne, obs[obs.size()-1].idle);
        end
        for (int t = 1; t < obs.size(); t++) begin
            total++;
            if (masked(obs[t]) !== masked(expv[t])) begin
                bad++; $display("FAIL eop_model cycle %0d: got %b required %b", t, obs[t], expv[t]);
            end
        end
    endtask

    task automatic test_jitter_alternating();
        start_scenario(1);
        tx_sync();
        repeat (4) tx_byte(8'($urandom));
        tx_eop();
        run_stim();
        collect(0);
        total++;
        if (got.size() != sent.size()) begin
            bad++; $display("FAIL jitter_len: got %0d bits required %0d", got.size(), sent.size());
        end
        for (int i = 0; i < sent.size() && i < got.size(); i++) begin
            total++;
            if (got[i] !== sent[i]) begin
                bad++; $display("FAIL jitter_bit %0d: got %b required %b", i, got[i], sent[i]);
            end
        end
        for (int t = 1; t < obs.size(); t++) begin
            total++;
            if (masked(obs[t]) !== masked(expv[t])) begin
                bad++; $display("FAIL jitter_model cycle %0d: got %b required %b", t, obs[t], expv[t]);
            end
        end
    endtask

    task automatic test_back_to_back();
        start_scenario(2);
        for (int p = 0; p < 4; p++) begin
            tx_sync();
            repeat ($urandom_range(1, 4)) tx_byte(8'($urandom));
            tx_eop();
            hold(1'b1, 1'b0, $urandom_range(2, 20));
        end
        run_stim();
        collect(0);
        total++;
        if (got.size() != sent.size()) begin
            bad++; $display("FAIL b2b_len: got %0d bits required %0d", got.size(), sent.size());
        end
        for (int i = 0; i < sent.size() && i < got.size(); i++) begin
            total++;
            if (got[i] !== sent[i]) begin
                bad++; $display("FAIL b2b_bit %0d: got %b required %b", i, got[i], sent[i]);
            end
        end
        for (int t = 1; t < obs.size(); t++) begin
            total++;
            if (masked(obs[t]) !== masked(expv[t])) begin
                bad++; $display("FAIL b2b_model cycle %0d: got %b required %b", t, obs[t], expv[t]);
            end
        end
    endtask

    task automatic test_rx_enable();
        int ns, ne, nx, nb;
        int mark;
        start_scenario(0);
        cur_en = 1'b0;
        tx_sync();
        tx_byte(8'hA5);
        tx_eop();
        mark = stim.size();
        cur_en = 1'b1;
        hold(1'b1, 1'b0, 10);
        tx_sync();
        tx_bit(1'b0); tx_bit(1'b1); tx_bit(1'b1);
        cur_en = 1'b0;
        tx_bit(1'b0); tx_bit(1'b1);
        cur_en = 1'b1;
        tx_byte(8'($urandom));
        tx_eop();
        run_stim();
        count_pulses(1, mark, ns, ne, nx, nb);
        total++;
        if (ns + ne + nx + nb != 0) begin
            bad++; $display("FAIL enable_quiet: got strobe=%0d eop=%0d serr=%0d busy=%0d required all 0", ns, ne, nx, nb);
        end
        for (int t = 1; t < obs.size(); t++) begin
            total++;
            if (masked(obs[t]) !== masked(expv[t])) begin
                bad++; $display("FAIL enable_model cycle %0d: got %b required %b", t, obs[t], expv[t]);
            end
        end
    endtask

    task automatic test_reset_mid_byte();
        int idx;
        stim_t r;
        logic [7:0] byte_v;
        start_scenario(0);
        tx_sync();
        tx_bit(1'b1); tx_bit(1'b0); tx_bit(1'b1);
        hold(lvl, ~lvl, 3);
        idx = stim.size();
        r = '{1'b1, 1'b0, 1'b1, 1'b1};
        stim.push_back(r);
        hold(1'b1, 1'b0, 12);
        lvl = 1'b1;
        sent.delete();
        tx_sync();
        tx_eop();
        run_stim();
        total++;
        if (obs[idx+1] !== RESET_OBS) begin
            bad++; $display("FAIL midreset_values: got %b required %b", obs[idx+1], RESET_OBS);
        end
        collect(idx + 2);
        byte_v = '0;
        for (int i = 0; i < 8 && i < got.size(); i++) byte_v[i] = got[i];
        total++;
        if (got.size() != 8 || byte_v !== 8'h80) begin
            bad++; $display("FAIL midreset_resync: got %0d bits value %h required 8 bits value 80", got.size(), byte_v);
        end
        for (int t = 1; t < obs.size(); t++) begin
            total++;
            if (masked(obs[t]) !== masked(expv[t])) begin
                bad++; $display("FAIL midreset_model cycle %0d: got %b required %b", t, obs[t], expv[t]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_line();
        test_sync();
        test_stuffed_ones();
        test_stuff_error();
        test_eop();
        test_jitter_alternating();
        test_back_to_back();
        test_rx_enable();
        test_reset_mid_byte();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
